mux_sel_pipe: RTL

//  Parametrised N-way WIDTH-bit operand selector with a registered output stage and a
//  2-entry skid buffer. Successor of the fixed 2/3/5/6-input combinational selectors.

---
 rtl/mux_sel_pipe_pkg.sv | 22 ++
 rtl/mux_sel_pipe_comb.sv | 44 ++++
 rtl/mux_sel_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mux_sel_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mux_sel_pipe_pkg
// Shared definitions for the registered operand selector:
//   - pipe_state_e : occupancy of the output stage (main register + skid entry)
//   - sel_in_range : decides whether a binary select addresses a real input
// -----------------------------------------------------------------------------
package mux_sel_pipe_pkg;

    // Occupancy of the output stage. ONE = main register full, TWO = main and
    // skid entry both full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // True when select value sel addresses one of the n populated inputs.
    function automatic logic sel_in_range(input int sel, input int n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/mux_sel_pipe_comb.sv
// -----------------------------------------------------------------------------
// mux_sel_pipe_comb
// Purely combinational NUM_IN-way selector over a packed input bus.
// Ports:
//   in_data  : NUM_IN*WIDTH packed inputs, input i at [i*WIDTH +: WIDTH]
//   in_sel   : binary select
//   sel_data : selected word, or DEFAULT_VAL when in_sel >= NUM_IN
//   sel_hit  : 1 when in_sel addressed a real input
// -----------------------------------------------------------------------------
module mux_sel_pipe_comb
    import mux_sel_pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 6,
    parameter int               SEL_W       = 3,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}}
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    sel_hit
);

    logic [WIDTH-1:0] or_tree_s;
    logic             hit_s;

    // AND-OR selection: each input is gated by its own select match, so no
    // variable part-select is needed and unused select codes fall out as zero.
    always_comb begin
        or_tree_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            or_tree_s = or_tree_s |
                        ({WIDTH{in_sel == SEL_W'(i)}} & in_data[i*WIDTH +: WIDTH]);
        end
    end

    // Range decision and substitution of the default word for unused codes.
    always_comb begin
        hit_s    = sel_in_range(int'(in_sel), NUM_IN);
        sel_data = hit_s ? or_tree_s : DEFAULT_VAL;
        sel_hit  = hit_s;
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// -----------------------------------------------------------------------------
// mux_sel_pipe
// N-way WIDTH-bit operand selector with a registered output stage and a
// 2-entry skid buffer (main register + one skid entry), valid/ready on both
// sides. One-cycle latency, one transfer per cycle while out_ready is high.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : synchronous flush, drops all buffered entries
//   in_data     : NUM_IN*WIDTH packed inputs
//   in_sel      : binary select
//   in_valid    : upstream offers a selection
//   in_ready    : block accepts this cycle (registered, no path from out_ready)
//   out_data    : selected word (registered)
//   out_hit     : 1 = select in range, 0 = DEFAULT_VAL substituted
//   out_valid   : out_data/out_hit are valid
//   out_ready   : downstream accepts this cycle
// -----------------------------------------------------------------------------
module mux_sel_pipe
    import mux_sel_pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 6,
    parameter int               SEL_W       = 3,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_hit,
    output logic                    out_valid,
    input  logic                    out_ready
);

    pipe_state_e      state_r;
    pipe_state_e      next_state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] main_data_r;
    logic             main_hit_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             skid_hit_r;

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_hit_s;
    logic             accept_s;
    logic             drain_s;
    logic             load_main_s;
    logic             load_skid_s;
    logic             skid_to_main_s;

    mux_sel_pipe_comb #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .sel_data (sel_data_s),
        .sel_hit  (sel_hit_s)
    );

    // Handshake terms; both use only registered flags on the local side.
    always_comb begin
        accept_s = in_valid & in_ready_r;
        drain_s  = out_valid_r & out_ready;
    end

    // Next-state and register-load decisions for the main/skid pair.
    always_comb begin
        next_state_s   = state_r;
        load_main_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
        if (flush) begin
            // Flush wins over any same-cycle accept: nothing is loaded.
            next_state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        next_state_s = ST_ONE;
                        load_main_s  = 1'b1;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        next_state_s = ST_ONE;
                        load_main_s  = 1'b1;
                    end else if (accept_s) begin
                        next_state_s = ST_TWO;
                        load_skid_s  = 1'b1;
                    end else if (drain_s) begin
                        next_state_s = ST_EMPTY;
                    end else begin
                        next_state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        next_state_s   = ST_ONE;
                        skid_to_main_s = 1'b1;
                    end else begin
                        next_state_s = ST_TWO;
                    end
                end
                default: begin
                    next_state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus the registered in_ready/out_valid flags derived
    // from the next state, so both outputs come straight from flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != ST_TWO);
            out_valid_r <= (next_state_s != ST_EMPTY);
        end
    end

    // Main (output) register: new selection or promoted skid entry; holds
    // otherwise, which keeps out_data stable under stall and across flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_data_r <= {WIDTH{1'b0}};
            main_hit_r  <= 1'b0;
        end else if (load_main_s) begin
            main_data_r <= sel_data_s;
            main_hit_r  <= sel_hit_s;
        end else if (skid_to_main_s) begin
            main_data_r <= skid_data_r;
            main_hit_r  <= skid_hit_r;
        end else begin
            main_data_r <= main_data_r;
            main_hit_r  <= main_hit_r;
        end
    end

    // Skid entry: captures the selection accepted while the output stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_data_r <= {WIDTH{1'b0}};
            skid_hit_r  <= 1'b0;
        end else if (load_skid_s) begin
            skid_data_r <= sel_data_s;
            skid_hit_r  <= sel_hit_s;
        end else begin
            skid_data_r <= skid_data_r;
            skid_hit_r  <= skid_hit_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_data_r;
    assign out_hit   = main_hit_r;

endmodule
